// File: rtl/cache_array_mp.sv
// cache_array_mp: parametrised cache storage array.
//   Byte-masked writes, two independent combinational read ports with
//   write-through bypass, and a per-entry valid bit. A flush engine
//   invalidates one entry per cycle while leaving the data untouched.
//
// Optional feature macro: CACHE_ARRAY_MP_PARITY_EN
//   When defined, one even-parity bit per entry is stored and checked on
//   non-bypassed reads. When undefined, perr0/perr1 are tied to 0.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   load, windex, wmask, datain     byte-masked write request
//   rindex0/1            read indices (combinational reads)
//   dataout0/1, valid0/1 read data and entry-valid per port
//   flush_req            start an invalidate-all sweep (sampled in IDLE)
//   flush_busy           sweep in progress
//   flush_done           single-cycle pulse after the sweep
//   perr0/1              parity error per read port
module cache_array_mp #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned IDX_W = $clog2(DEPTH),
  localparam int unsigned BE_W  = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [IDX_W-1:0] windex,
  input  logic [BE_W-1:0]  wmask,
  input  logic [WIDTH-1:0] datain,
  input  logic [IDX_W-1:0] rindex0,
  input  logic [IDX_W-1:0] rindex1,
  output logic [WIDTH-1:0] dataout0,
  output logic [WIDTH-1:0] dataout1,
  output logic             valid0,
  output logic             valid1,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic             flush_done,
  output logic             perr0,
  output logic             perr1
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_ptr;
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;

  logic             w_busy;
  logic             w_wr;
  logic             w_sweep_last;
  logic             w_byp0;
  logic             w_byp1;
  logic [WIDTH-1:0] w_merge;

  assign w_busy       = (r_state == S_SWEEP);
  assign flush_busy   = w_busy;
  assign flush_done   = (r_state == S_DONE);
  // Writes are dropped during a sweep so they cannot race the invalidation.
  assign w_wr         = load && !w_busy && (wmask != '0);
  assign w_sweep_last = (r_ptr == IDX_W'(DEPTH - 1));

  // Flush FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Flush FSM next state; flush_req only matters in IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (flush_req) w_state_nxt = S_SWEEP;
      S_SWEEP: if (w_sweep_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sweep pointer: held at 0 outside SWEEP so every sweep starts at entry 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_busy) begin
      r_ptr <= r_ptr + IDX_W'(1);
    end else begin
      r_ptr <= '0;
    end
  end

  // Byte merge of write data over the currently stored word
  always_comb begin
    w_merge = r_data[windex];
    for (int b = 0; b < int'(BE_W); b++) begin
      if (wmask[b]) w_merge[8*b +: 8] = datain[8*b +: 8];
    end
  end

  // Storage and valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_data[i] <= '0;
      end
      r_valid <= '0;
    end else begin
      if (w_wr) begin
        r_data[windex]  <= w_merge;
        r_valid[windex] <= 1'b1;
      end
      if (w_busy) begin
        r_valid[r_ptr] <= 1'b0;
      end
    end
  end

  // Read ports with write-through bypass; valids masked while sweeping
  assign w_byp0   = w_wr && (rindex0 == windex);
  assign w_byp1   = w_wr && (rindex1 == windex);
  assign dataout0 = w_byp0 ? w_merge : r_data[rindex0];
  assign dataout1 = w_byp1 ? w_merge : r_data[rindex1];
  assign valid0   = !w_busy && (w_byp0 || r_valid[rindex0]);
  assign valid1   = !w_busy && (w_byp1 || r_valid[rindex1]);

`ifdef CACHE_ARRAY_MP_PARITY_EN
  logic [DEPTH-1:0] r_par;

  // Even parity over the full merged word, captured on each effective write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par <= '0;
    end else if (w_wr) begin
      r_par[windex] <= ^w_merge;
    end
  end

  assign perr0 = valid0 && !w_byp0 && ((^r_data[rindex0]) != r_par[rindex0]);
  assign perr1 = valid1 && !w_byp1 && ((^r_data[rindex1]) != r_par[rindex1]);
`else
  assign perr0 = 1'b0;
  assign perr1 = 1'b0;
`endif

endmodule

// File: tb/tb_cache_array_mp.sv
// Testbench for cache_array_mp (default WIDTH=32, DEPTH=8).
module tb_cache_array_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [2:0]  windex;
  logic [3:0]  wmask;
  logic [31:0] datain;
  logic [2:0]  rindex0;
  logic [2:0]  rindex1;
  logic [31:0] dataout0;
  logic [31:0] dataout1;
  logic        valid0;
  logic        valid1;
  logic        flush_req;
  logic        flush_busy;
  logic        flush_done;
  logic        perr0;
  logic        perr1;

  cache_array_mp dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .windex     (windex),
    .wmask      (wmask),
    .datain     (datain),
    .rindex0    (rindex0),
    .rindex1    (rindex1),
    .dataout0   (dataout0),
    .dataout1   (dataout1),
    .valid0     (valid0),
    .valid1     (valid1),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
    .flush_done (flush_done),
    .perr0      (perr0),
    .perr1      (perr1)
  );

  always #5 clk = ~clk;

  // Observation vector: {d0, d1, v0, v1, busy, done, perr0, perr1}
  typedef struct {
    string       nm;
    logic [69:0] val;
  } exp_t;

  typedef struct {
    logic        ld;
    logic [2:0]  wi;
    logic [3:0]  wm;
    logic [31:0] di;
    logic [2:0]  r0;
    logic [2:0]  r1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        ev0;
    logic        ev1;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[10];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [69:0] obs();
    return {dataout0, dataout1, valid0, valid1, flush_busy, flush_done, perr0, perr1};
  endfunction

  task automatic expect_obs(input string nm, input logic [31:0] d0, input logic [31:0] d1,
                            input logic v0, input logic v1, input logic b, input logic dn,
                            input logic [1:0] pe = 2'b00);
    exp_t e;
    e.nm  = nm;
    e.val = {d0, d1, v0, v1, b, dn, pe};
    sb.push_back(e);
  endtask

  // Pop every pending expectation and compare against the DUT right now
  task automatic check_now();
    exp_t e;
    logic [69:0] a;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = obs();
      n_cmp++;
      if (a !== e.val) begin
        n_bad++;
        $display("FAIL %s: actual d0=%h d1=%h v=%b%b busy=%b done=%b perr=%b%b required d0=%h d1=%h v=%b%b busy=%b done=%b perr=%b%b",
                 e.nm, a[69:38], a[37:6], a[5], a[4], a[3], a[2], a[1], a[0],
                 e.val[69:38], e.val[37:6], e.val[5], e.val[4], e.val[3], e.val[2], e.val[1], e.val[0]);
      end
    end
  endtask

  task automatic cmp_int(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_now();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load      = 1'b0;
    windex    = '0;
    wmask     = '0;
    datain    = '0;
    flush_req = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] wi, input logic [31:0] di);
    load = 1'b1; windex = wi; wmask = 4'hF; datain = di;
    tick();
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] ex;
    logic        ev;

    tbl[0] = '{1'b1, 3'd3, 4'hF, 32'hDEADBEEF, 3'd3, 3'd0, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 3'd3, 4'h5, 32'h11223344, 3'd3, 3'd3, 32'hDE22BE44, 32'hDE22BE44, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 3'd0, 4'h0, 32'h0,        3'd3, 3'd1, 32'hDE22BE44, 32'h0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 3'd5, 4'hF, 32'hAAAAAAAA, 3'd4, 3'd6, 32'h0, 32'h0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 3'd4, 4'hF, 32'h12345678, 3'd5, 3'd3, 32'hAAAAAAAA, 32'hDE22BE44, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 3'd5, 4'h3, 32'h55555555, 3'd5, 3'd4, 32'hAAAA5555, 32'h12345678, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 3'd6, 4'h0, 32'hFFFFFFFF, 3'd6, 3'd5, 32'h0, 32'hAAAA5555, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 3'd0, 4'h0, 32'h0,        3'd6, 3'd5, 32'h0, 32'hAAAA5555, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 3'd0, 4'h8, 32'hCAFEF00D, 3'd0, 3'd7, 32'hCA000000, 32'h0, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 3'd0, 4'h0, 32'h0,        3'd0, 3'd0, 32'hCA000000, 32'hCA000000, 1'b1, 1'b1};

    rst = 1'b1;
    idle_inputs();
    rindex0 = '0;
    rindex1 = '0;
    #2;
    expect_obs("in_reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_now();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Post-reset contents
    for (int i = 0; i < 8; i++) begin
      rindex0 = 3'(i);
      rindex1 = 3'(7 - i);
      expect_obs($sformatf("reset_read_%0d", i), 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      sample();
      tick();
    end

    // Table-driven writes, merges, bypass and no-op mask
    for (int i = 0; i < 10; i++) begin
      load = tbl[i].ld; windex = tbl[i].wi; wmask = tbl[i].wm; datain = tbl[i].di;
      rindex0 = tbl[i].r0; rindex1 = tbl[i].r1;
      expect_obs($sformatf("vec_%0d", i), tbl[i].e0, tbl[i].e1, tbl[i].ev0, tbl[i].ev1, 1'b0, 1'b0);
      sample();
      tick();
    end
    idle_inputs();

    // Fill all entries, then sweep with a dropped write and ignored flush_req
    for (int i = 0; i < 8; i++) do_write(3'(i), 32'h1000_0000 + i);
    rindex0 = 3'd2;
    rindex1 = 3'd0;
    flush_req = 1'b1;
    expect_obs("flush_req_cycle", 32'h10000002, 32'h10000000, 1'b1, 1'b1, 1'b0, 1'b0);
    sample();
    tick();
    flush_req = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) begin
        load = 1'b1; windex = 3'd2; wmask = 4'hF; datain = 32'hBAD0BAD0;
        flush_req = 1'b1;
      end
      expect_obs($sformatf("sweep_%0d", c), 32'h10000002, 32'h10000000, 1'b0, 1'b0, 1'b1, 1'b0);
      sample();
      tick();
      idle_inputs();
    end
    // DONE cycle: write is accepted and bypassed
    load = 1'b1; windex = 3'd7; wmask = 4'hF; datain = 32'h77777777;
    rindex0 = 3'd7;
    rindex1 = 3'd2;
    expect_obs("done_cycle", 32'h77777777, 32'h10000002, 1'b1, 1'b0, 1'b0, 1'b1);
    sample();
    tick();
    idle_inputs();
    expect_obs("after_done_1", 32'h77777777, 32'h10000002, 1'b1, 1'b0, 1'b0, 1'b0);
    sample();
    tick();
    expect_obs("no_second_sweep", 32'h77777777, 32'h10000002, 1'b1, 1'b0, 1'b0, 1'b0);
    sample();
    tick();
    for (int i = 0; i < 8; i++) begin
      rindex0 = 3'(i);
      rindex1 = 3'(i);
      ex = (i == 7) ? 32'h77777777 : 32'h1000_0000 + i;
      ev = (i == 7);
      expect_obs($sformatf("post_flush_%0d", i), ex, ex, ev, ev, 1'b0, 1'b0);
      sample();
      tick();
    end

    // Async reset in the middle of a sweep, between clock edges
    rindex0 = '0;
    rindex1 = 3'd7;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    expect_obs("async_rst_mid_sweep", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_now();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) do_write(3'(i), 32'hA0 + i);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!flush_busy) break;
      n++;
      @(posedge clk);
      #1;
    end
    cmp_int("sweep_len_after_reset", n, 8);
    expect_obs("done_after_reset_sweep", 32'hA0, 32'hA7, 1'b0, 1'b0, 1'b0, 1'b1);
    check_now();
    tick();
    for (int i = 0; i < 8; i++) begin
      rindex0 = 3'(i);
      rindex1 = 3'(i);
      expect_obs($sformatf("reset_sweep_inval_%0d", i), 32'hA0 + i, 32'hA0 + i,
                 1'b0, 1'b0, 1'b0, 1'b0);
      sample();
      tick();
    end

`ifdef CACHE_ARRAY_MP_PARITY_EN
    do_write(3'd1, 32'h0000000F);
    rindex0 = 3'd1;
    rindex1 = 3'd0;
    expect_obs("parity_clean", 32'h0000000F, 32'hA0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    sample();
    dut.r_data[1] = 32'h0000000E;
    #1;
    expect_obs("parity_err", 32'h0000000E, 32'hA0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10);
    check_now();
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_array_mp.md
Name: cache_array_mp

Overview:
- Parametrised successor to the team's 8-entry cache storage array.
- Provides configurable depth and width, byte-masked writes, and two independent combinational read ports with write-through bypass.
- Each entry carries a valid bit; a sequential flush engine invalidates all entries one index per cycle.
- Used for cache data/tag/valid storage where line invalidation and dual lookup are needed.

Parameters:
- WIDTH, 32, data bits per entry; must be a multiple of 8.
- DEPTH, 8, number of entries; power of two, at least 2.
- Derived, not overridable: IDX_W = $clog2(DEPTH); BE_W = WIDTH/8.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- load  in  1  write enable.
- windex  in  IDX_W  write index.
- wmask  in  BE_W  byte enables; bit i covers datain[8i+7:8i].
- datain  in  WIDTH  write data.
- rindex0  in  IDX_W  read port 0 index.
- rindex1  in  IDX_W  read port 1 index.
- dataout0  out  WIDTH  read port 0 data.
- dataout1  out  WIDTH  read port 1 data.
- valid0  out  1  read port 0 entry valid.
- valid1  out  1  read port 1 entry valid.
- flush_req  in  1  start invalidate-all sweep.
- flush_busy  out  1  sweep in progress.
- flush_done  out  1  one-cycle pulse when the sweep completes.
- perr0  out  1  port 0 parity error (optional feature).
- perr1  out  1  port 1 parity error (optional feature).

Behaviour:
- Reset (async assert, applies immediately, including mid-sweep):
  - all data = 0, all valid = 0, parity bits = 0.
  - FSM = IDLE, sweep pointer = 0, flush_busy = 0, flush_done = 0.
- Effective write: load && !flush_busy && wmask != 0.
  - At posedge, only the enabled bytes of data[windex] are updated; valid[windex] <= 1.
  - load with wmask == 0 is a no-op.
  - load while flush_busy is dropped entirely.
- Reads are combinational, zero latency; ports 0 and 1 are fully independent and may use the same index.
- Bypass, per port, when an effective write is present and rindexN == windex:
  - dataoutN = per-byte merge (datain byte where wmask bit = 1, otherwise stored byte).
  - validN = 1.
- Otherwise dataoutN = data[rindexN] and validN = valid[rindexN].
- While flush_busy = 1, valid0 and valid1 are forced to 0; data outputs are still driven from storage.
- Flush FSM, three states:
  - IDLE: flush_req -> SWEEP with pointer = 0.
  - SWEEP: flush_busy = 1; each cycle valid[pointer] <= 0 and pointer increments.
    - When pointer == DEPTH-1 is cleared -> DONE.
    - Sweep occupies exactly DEPTH cycles.
  - DONE: flush_busy = 0, flush_done = 1 for this single cycle -> IDLE.
  - flush_req is sampled only in IDLE; it is ignored in SWEEP and DONE (no queuing).
- Data contents are never cleared by a flush.
- A write issued in the DONE cycle or later is accepted normally.

Optional Feature:
- Macro: CACHE_ARRAY_MP_PARITY_EN.
- When defined:
  - one even-parity bit per entry is stored, computed over the full merged word on every effective write.
  - perrN = validN && !bypassN && (^data[rindexN] != parity[rindexN]).
  - perrN is 0 whenever the corresponding port is bypassing.
- When undefined: no parity storage is built; perr0 = perr1 = 0 constantly. The ports remain present.

Test Plan:
- Reset, then read indices 0..DEPTH-1 on both ports -> dataout = 0, valid = 0, flush_busy = 0, perr = 0.
- Write idx 3, datain 0xDEADBEEF, wmask 4'b1111, then write idx 3, datain 0x11223344, wmask 4'b0101 -> next-cycle read idx 3 returns 0xDE22BE44, valid = 1.
- Same-cycle bypass: storage idx 5 = 0xAAAAAAAA; load idx 5, datain 0x55555555, wmask 4'b0011, with rindex0 = 5 and rindex1 = 4 -> dataout0 = 0xAAAA5555, valid0 = 1; port 1 returns stored idx 4 unaffected.
- Flush with DEPTH = 8: fill all entries valid, pulse flush_req -> flush_busy high exactly 8 cycles, flush_done high on cycle 9 only; valid reads 0 everywhere afterwards; data is retained.
- Write during SWEEP (idx 2, wmask 4'b1111) plus a second flush_req mid-sweep -> write dropped, no second sweep; idx 2 reads invalid with old data after DONE.
- Async reset asserted mid-sweep, between clock edges -> flush_busy falls immediately; after release a new flush_req starts a full DEPTH-cycle sweep from index 0. With CACHE_ARRAY_MP_PARITY_EN defined, force-flip a stored data bit -> perr = 1 on a valid non-bypass read.
